puc_pkt_sched: RTL and testbench

Packet scheduler for the PUC data collector. On a start strobe it collects exactly NUM_ITEMS 64-bit data items from the collector. For each item it issues one `rdy_for_nxt_pkt` advance strobe, waits for the returned `puc_data_strb`, and writes the word into the SDC host-bus FIFO, stalling on FIFO full. The block sits between the SD-write control logic (start/done) and the collector/FIFO pair. It also bounds each item fetch with a timeout.

---
 rtl/puc_pkt_sched.sv | 142 ++++++++++++++
 tb/tb_puc_pkt_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/puc_pkt_sched.sv
// rtl/puc_pkt_sched.sv - PUC packet scheduler: collector fetch, FIFO write, per-item timeout
//
// Purpose: on a start strobe, fetches NUM_ITEMS 64-bit items from the PUC
// collector one at a time (advance strobe, wait for data strobe) and writes
// each into the SDC host-bus FIFO, stalling while the FIFO is full. Each
// fetch is bounded by TIMEOUT cycles; a timeout ends the packet early and
// raises a sticky error flag.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_strt_pkt_strb       one-clock packet start request (accepted in IDLE only)
//   o_rdy_for_nxt_pkt     one-clock advance strobe to the collector
//   i_puc_data            item from the collector
//   i_puc_data_strb       i_puc_data valid (captured in WAIT only)
//   i_fifo_full           FIFO cannot accept a write
//   o_fifo_wr_data        word to the FIFO
//   o_fifo_wr_en          one-clock FIFO write strobe
//   o_busy                packet in progress
//   o_item_cnt            items written in the current packet
//   o_pkt_done_strb       one-clock end-of-packet strobe
//   o_timeout_err         sticky fetch-timeout flag, cleared by the next start
module puc_pkt_sched #(
   parameter int NUM_ITEMS = 63,
   parameter int TIMEOUT   = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_strt_pkt_strb,
   output logic        o_rdy_for_nxt_pkt,
   input  logic [63:0] i_puc_data,
   input  logic        i_puc_data_strb,
   input  logic        i_fifo_full,
   output logic [63:0] o_fifo_wr_data,
   output logic        o_fifo_wr_en,
   output logic        o_busy,
   output logic [7:0]  o_item_cnt,
   output logic        o_pkt_done_strb,
   output logic        o_timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [7:0] C_NUM_ITEMS = 8'(NUM_ITEMS);
   localparam logic [7:0] C_TIMEOUT   = 8'(TIMEOUT);

   state_t      r_state;
   logic [7:0]  r_timer;
   logic [7:0]  r_item_cnt;
   logic [63:0] r_fifo_wr_data;
   logic        r_fifo_wr_en;
   logic        r_rdy;
   logic        r_busy;
   logic        r_done;
   logic        r_timeout_err;
   logic [7:0]  w_cnt_nxt;

   assign w_cnt_nxt = r_item_cnt + 8'd1;

   // Strobe-type outputs are registered alongside the state so that each
   // is high exactly in the cycle the FSM occupies the matching state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_timer        <= 8'd0;
         r_item_cnt     <= 8'd0;
         r_fifo_wr_data <= 64'd0;
         r_fifo_wr_en   <= 1'b0;
         r_rdy          <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         r_fifo_wr_en <= 1'b0;
         r_rdy        <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_strt_pkt_strb) begin
                  r_item_cnt    <= 8'd0;
                  r_timeout_err <= 1'b0;
                  r_state       <= S_REQ;
                  r_rdy         <= 1'b1;
                  r_busy        <= 1'b1;
               end
            end
            S_REQ: begin
               r_timer <= C_TIMEOUT;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // A data strobe on the timer==0 cycle still wins over the timeout.
               if (i_puc_data_strb) begin
                  r_fifo_wr_data <= i_puc_data;
                  r_state        <= S_WRITE;
               end else if (r_timer == 8'd0) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= S_DONE;
                  r_done        <= 1'b1;
               end else begin
                  r_timer <= r_timer - 8'd1;
               end
            end
            S_WRITE: begin
               if (!i_fifo_full) begin
                  r_fifo_wr_en <= 1'b1;
                  r_item_cnt   <= w_cnt_nxt;
                  if (w_cnt_nxt == C_NUM_ITEMS) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_REQ;
                     r_rdy   <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_rdy_for_nxt_pkt = r_rdy;
   assign o_fifo_wr_data    = r_fifo_wr_data;
   assign o_fifo_wr_en      = r_fifo_wr_en;
   assign o_busy            = r_busy;
   assign o_item_cnt        = r_item_cnt;
   assign o_pkt_done_strb   = r_done;
   assign o_timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_puc_pkt_sched.sv
// tb/tb_puc_pkt_sched.sv - self-checking bench for puc_pkt_sched
module tb_puc_pkt_sched;

   localparam int NUM_ITEMS = 63;
   localparam int TIMEOUT   = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic        strt;
   logic [63:0] puc_data;
   logic        puc_strb;
   logic        full;
   logic        rdy;
   logic [63:0] wr_data;
   logic        wr_en;
   logic        busy;
   logic [7:0]  item_cnt;
   logic        done;
   logic        to_err;

   always #5 clk = ~clk;

   puc_pkt_sched #(.NUM_ITEMS(NUM_ITEMS), .TIMEOUT(TIMEOUT)) dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_strt_pkt_strb   (strt),
      .o_rdy_for_nxt_pkt (rdy),
      .i_puc_data        (puc_data),
      .i_puc_data_strb   (puc_strb),
      .i_fifo_full       (full),
      .o_fifo_wr_data    (wr_data),
      .o_fifo_wr_en      (wr_en),
      .o_busy            (busy),
      .o_item_cnt        (item_cnt),
      .o_pkt_done_strb   (done),
      .o_timeout_err     (to_err)
   );

   typedef struct {
      int lat;       // collector latency, advance strobe to data strobe
      int full_at;   // item whose write is stalled by fifo_full (-1: none)
      int full_len;  // stall length in cycles
      int hold_at;   // item the collector never answers (-1: none)
      int junk;      // inject spurious starts / data strobes
      int exp_wr;
      int exp_rdy;
      int exp_cnt;
      int exp_to;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] sb_q[$];

   int cyc_no;
   int lat, full_at, full_len, hold_at, junk;
   int pend, cd, idx, full_cnt, junk_next;
   logic [63:0] pdata;
   int n_wr, n_rdy, n_done, last_rdy, per_bad, done_cyc, done_with_wr;
   int stall_wr_exp, rdy_in_full, unstable;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_pkt_stats();
      sb_q.delete();
      pend = 0; cd = 0; idx = 0; full_cnt = 0; junk_next = 0;
      n_wr = 0; n_rdy = 0; n_done = 0; last_rdy = -1; per_bad = 0;
      done_cyc = -1; done_with_wr = 0; stall_wr_exp = -1;
      rdy_in_full = 0; unstable = 0;
   endtask

   // One clock: wait for the edge, observe outputs 1ns later, then drive the
   // collector/FIFO model inputs for the current cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc_no++;
      strt     = 1'b0;
      puc_strb = 1'b0;
      puc_data = 64'd0;
      if (full_cnt > 0) begin
         full = 1'b1;
         full_cnt--;
         if (full_cnt == 0) stall_wr_exp = cyc_no + 2;
      end else begin
         full = 1'b0;
      end
      if (junk_next != 0) begin
         puc_strb  = 1'b1;
         puc_data  = 64'hBAD0_BAD0_BAD0_BAD0;
         strt      = 1'b1;
         junk_next = 0;
      end
      if (done) begin
         n_done++;
         done_cyc     = cyc_no;
         done_with_wr = int'(wr_en);
         pend         = 0;
         if (junk != 0) strt = 1'b1;
      end
      if (pend != 0) begin
         cd--;
         if (cd == 0) begin
            puc_strb = 1'b1;
            puc_data = pdata;
            sb_q.push_back(pdata);
            pend = 0;
            if (int'(pdata) == full_at) full_cnt = full_len;
            if (junk != 0) junk_next = 1;
         end
      end
      if (full && (wr_data !== 64'(full_at))) unstable++;
      if (wr_en) begin
         if (sb_q.size() == 0) begin
            check("unexpected_write", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check("wr_data", wr_data, sb_q.pop_front());
         end
         if (full_len > 0 && n_wr == full_at) check("stall_wr_cycle", 64'(cyc_no), 64'(stall_wr_exp));
         n_wr++;
      end
      if (rdy) begin
         n_rdy++;
         if (full) rdy_in_full++;
         if (last_rdy >= 0 && (cyc_no - last_rdy) != lat + 2) per_bad++;
         last_rdy = cyc_no;
         if (idx != hold_at) begin
            pend  = 1;
            cd    = lat;
            pdata = 64'(idx);
         end
         idx++;
         if (junk != 0) begin
            puc_strb = 1'b1;
            puc_data = 64'hDEAD_DEAD_DEAD_DEAD;
            strt     = 1'b1;
         end
      end
   endtask

   task automatic run_pkt(input vec_t v, input int num);
      string tag;
      tag = $sformatf("v%0d", num);
      lat = v.lat; full_at = v.full_at; full_len = v.full_len;
      hold_at = v.hold_at; junk = v.junk;
      clear_pkt_stats();
      tick();
      strt = 1'b1;
      tick();
      check({tag, "_start_rdy"}, 64'(rdy), 64'd1);
      check({tag, "_start_clears_err"}, 64'(to_err), 64'd0);
      for (int t = 0; t < 20000 && n_done == 0; t++) tick();
      check({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
      tick();
      check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
      for (int t = 0; t < 4; t++) tick();
      check({tag, "_writes"}, 64'(n_wr), 64'(v.exp_wr));
      check({tag, "_advances"}, 64'(n_rdy), 64'(v.exp_rdy));
      check({tag, "_done_count"}, 64'(n_done), 64'd1);
      check({tag, "_item_cnt"}, 64'(item_cnt), 64'(v.exp_cnt));
      check({tag, "_timeout_err"}, 64'(to_err), 64'(v.exp_to));
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
      if (v.exp_to != 0) begin
         check({tag, "_timeout_latency"}, 64'(done_cyc - last_rdy), 64'(TIMEOUT + 2));
         check({tag, "_no_write_at_done"}, 64'(done_with_wr), 64'd0);
      end else begin
         check({tag, "_done_with_last_wr"}, 64'(done_with_wr), 64'd1);
      end
      if (v.full_len == 0) begin
         check({tag, "_period"}, 64'(per_bad), 64'd0);
      end else begin
         check({tag, "_no_rdy_in_stall"}, 64'(rdy_in_full), 64'd0);
         check({tag, "_stable_in_stall"}, 64'(unstable), 64'd0);
      end
   endtask

   initial begin
      vec_t tbl[6];
      tbl[0] = '{6,   -1, 0,  -1, 0, 63, 63, 63, 0};  // plain packet, L=6
      tbl[1] = '{6,   10, 20, -1, 0, 63, 63, 63, 0};  // FIFO stall at item 10
      tbl[2] = '{2,   -1, 0,  4,  0, 4,  5,  4,  1};  // 5th item withheld
      tbl[3] = '{256, -1, 0,  -1, 0, 63, 63, 63, 0};  // strobe on timer==0 cycle
      tbl[4] = '{257, -1, 0,  -1, 0, 0,  1,  0,  1};  // one cycle too late
      tbl[5] = '{1,   -1, 0,  -1, 1, 63, 63, 63, 0};  // spurious start/data strobes

      cyc_no = 0;
      reset = 1'b1; strt = 1'b0; puc_strb = 1'b0; puc_data = 64'd0; full = 1'b0;
      lat = 1; full_at = -1; full_len = 0; hold_at = -1; junk = 0;
      clear_pkt_stats();
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_rdy", 64'(rdy), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_wr_data", wr_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_item_cnt", 64'(item_cnt), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_to_err", 64'(to_err), 64'd0);

      for (int i = 0; i < 6; i++) run_pkt(tbl[i], i);

      // Reset mid-packet at item 30, then a fresh full packet.
      lat = 6; full_at = -1; full_len = 0; hold_at = -1; junk = 0;
      clear_pkt_stats();
      tick();
      strt = 1'b1;
      for (int t = 0; t < 2000 && n_wr < 30; t++) tick();
      check("reach_item30", 64'(n_wr), 64'd30);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_outputs", {rdy, wr_en, done, to_err, item_cnt}, 12'd0);
      check("midrst_wr_data", wr_data, 64'd0);
      clear_pkt_stats();
      for (int t = 0; t < 300; t++) tick();
      check("midrst_no_done", 64'(n_done), 64'd0);
      check("midrst_no_activity", 64'(n_rdy + n_wr), 64'd0);
      run_pkt(tbl[0], 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
